// File: rtl/ram_dma_controller.sv
// DMA engine moving word blocks between the 512-word scratchpad and an external burst bus.
// Configured and started through the custom-instruction port; drives the scratchpad's second port.
module ram_dma_controller #(
  parameter logic [7:0]  customId = 8'h00,
  parameter int unsigned maxBurst = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic [31:0] result,
  output logic        done,
  output logic [8:0]  memAddress,
  output logic        memWriteEnable,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData,
  output logic        busRequest,
  input  logic        busGrant,
  output logic        busStart,
  output logic        busRead,
  output logic [31:0] busAddress,
  output logic [7:0]  busBurstLength,
  output logic [31:0] busWriteData,
  output logic        busWriteValid,
  input  logic        busWriteReady,
  input  logic [31:0] busReadData,
  input  logic        busReadValid,
  input  logic        busEnd,
  input  logic        busError
);

  localparam int unsigned DataW = 32;
  localparam int unsigned MemAw = 9;
  localparam int unsigned SizeW = 10;
  localparam int unsigned LenW  = 9;
  localparam int unsigned BlenW = 8;

  localparam logic [SizeW-1:0] MaxBlock = SizeW'(512);
  localparam logic [LenW-1:0]  MaxLen   = LenW'(maxBurst);

  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_START, S_READ, S_WRITE, S_WAIT_END, S_NEXT
  } state_t;

  // Write-burst beat pipeline: present address, capture read data, hold for the slave.
  typedef enum logic [1:0] {PH_ADDR, PH_DATA, PH_HOLD} phase_t;

  state_t state, state_nxt;
  phase_t phase, phase_nxt;

  logic [DataW-1:0] cfg_bus_addr, cfg_bus_addr_nxt;
  logic [MemAw-1:0] cfg_mem_addr, cfg_mem_addr_nxt;
  logic [SizeW-1:0] cfg_block, cfg_block_nxt;
  logic [BlenW-1:0] cfg_burst, cfg_burst_nxt;
  logic             error, error_nxt;
  logic             dir_read, dir_read_nxt;

  logic [DataW-1:0] work_bus_addr, work_bus_addr_nxt;
  logic [MemAw-1:0] work_mem_addr, work_mem_addr_nxt;
  logic [SizeW-1:0] remaining, remaining_nxt;
  logic [LenW-1:0]  cur_len, cur_len_nxt;
  logic [LenW-1:0]  beat_cnt, beat_cnt_nxt;

  logic [DataW-1:0] result_nxt;
  logic             done_nxt;
  logic [MemAw-1:0] mem_addr_nxt;
  logic             mem_we_nxt;
  logic [DataW-1:0] mem_wdata_nxt;
  logic             bus_req_nxt;
  logic             bus_start_nxt;
  logic             bus_read_nxt;
  logic [DataW-1:0] bus_addr_nxt;
  logic [BlenW-1:0] bus_len_nxt;
  logic [DataW-1:0] wdata_nxt;
  logic             wvalid_nxt;

  logic             sel_hit;
  logic             wr_en;
  logic [2:0]       sel;
  logic             busy;
  logic             go_cmd;
  logic [DataW-1:0] rd_mux;
  logic [LenW-1:0]  burst_cfg;
  logic [LenW-1:0]  burst_len;
  logic             unused_bits;

  assign sel_hit     = start && (ciN == customId);
  assign sel         = valueA[12:10];
  assign wr_en       = valueA[9];
  assign busy        = (state != S_IDLE);
  assign go_cmd      = sel_hit && wr_en && (sel == 3'd5) && (valueB[0] || valueB[1]) && !busy;
  assign unused_bits = ^{valueA[31:13], valueA[8:0]};

  always_comb begin
    unique case (sel)
      3'd1:    rd_mux = cfg_bus_addr;
      3'd2:    rd_mux = DataW'(cfg_mem_addr);
      3'd3:    rd_mux = DataW'(cfg_block);
      3'd4:    rd_mux = DataW'(cfg_burst);
      3'd5:    rd_mux = DataW'({error, busy});
      default: rd_mux = '0;
    endcase
  end

  // Length of the next burst: configured size clamped to the bus limit and to what is left.
  always_comb begin
    burst_cfg = LenW'(cfg_burst) + LenW'(1);
    if (burst_cfg > MaxLen) burst_cfg = MaxLen;
    burst_len = (SizeW'(burst_cfg) > remaining) ? LenW'(remaining) : burst_cfg;
  end

  always_comb begin
    state_nxt         = state;
    phase_nxt         = phase;
    cfg_bus_addr_nxt  = cfg_bus_addr;
    cfg_mem_addr_nxt  = cfg_mem_addr;
    cfg_block_nxt     = cfg_block;
    cfg_burst_nxt     = cfg_burst;
    error_nxt         = error;
    dir_read_nxt      = dir_read;
    work_bus_addr_nxt = work_bus_addr;
    work_mem_addr_nxt = work_mem_addr;
    remaining_nxt     = remaining;
    cur_len_nxt       = cur_len;
    beat_cnt_nxt      = beat_cnt;
    done_nxt          = sel_hit;
    result_nxt        = (sel_hit && !wr_en) ? rd_mux : '0;
    mem_addr_nxt      = memAddress;
    mem_we_nxt        = 1'b0;
    mem_wdata_nxt     = '0;
    bus_start_nxt     = 1'b0;
    bus_read_nxt      = 1'b0;
    bus_addr_nxt      = '0;
    bus_len_nxt       = '0;
    wdata_nxt         = busWriteData;
    wvalid_nxt        = busWriteValid;

    if (sel_hit && wr_en && !busy) begin
      unique case (sel)
        3'd1:    cfg_bus_addr_nxt = {valueB[31:2], 2'b00};
        3'd2:    cfg_mem_addr_nxt = valueB[8:0];
        3'd3:    cfg_block_nxt    = (valueB > DataW'(MaxBlock)) ? MaxBlock : valueB[9:0];
        3'd4:    cfg_burst_nxt    = valueB[7:0];
        default: ;
      endcase
    end

    unique case (state)
      S_IDLE: begin
        if (go_cmd) begin
          error_nxt = 1'b0;
          if (cfg_block != '0) begin
            state_nxt         = S_REQUEST;
            dir_read_nxt      = valueB[0];
            work_bus_addr_nxt = cfg_bus_addr;
            work_mem_addr_nxt = cfg_mem_addr;
            remaining_nxt     = cfg_block;
          end
        end
      end
      S_REQUEST: begin
        if (busGrant) begin
          state_nxt     = S_START;
          cur_len_nxt   = burst_len;
          beat_cnt_nxt  = '0;
          bus_start_nxt = 1'b1;
          bus_read_nxt  = dir_read;
          bus_addr_nxt  = work_bus_addr;
          bus_len_nxt   = BlenW'(burst_len - LenW'(1));
        end
      end
      S_START: begin
        if (dir_read) begin
          state_nxt = S_READ;
        end else begin
          state_nxt    = S_WRITE;
          phase_nxt    = PH_ADDR;
          mem_addr_nxt = work_mem_addr;
        end
      end
      S_READ: begin
        // A beat arriving together with busEnd is still written.
        if (busReadValid && (beat_cnt < cur_len)) begin
          mem_we_nxt        = 1'b1;
          mem_addr_nxt      = work_mem_addr;
          mem_wdata_nxt     = busReadData;
          work_mem_addr_nxt = work_mem_addr + MemAw'(1);
          beat_cnt_nxt      = beat_cnt + LenW'(1);
        end
        if (busEnd) state_nxt = S_NEXT;
      end
      S_WRITE: begin
        unique case (phase)
          PH_ADDR: phase_nxt = PH_DATA;
          PH_DATA: begin
            wdata_nxt    = memReadData;
            wvalid_nxt   = 1'b1;
            mem_addr_nxt = memAddress + MemAw'(1);
            phase_nxt    = PH_HOLD;
          end
          default: begin
            if (busWriteReady) begin
              wvalid_nxt        = 1'b0;
              work_mem_addr_nxt = work_mem_addr + MemAw'(1);
              beat_cnt_nxt      = beat_cnt + LenW'(1);
              if (beat_cnt == cur_len - LenW'(1)) begin
                state_nxt = busEnd ? S_NEXT : S_WAIT_END;
              end else begin
                phase_nxt = PH_DATA;
              end
            end
          end
        endcase
      end
      S_WAIT_END: begin
        if (busEnd) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        remaining_nxt     = remaining - SizeW'(cur_len);
        work_bus_addr_nxt = work_bus_addr + DataW'({cur_len, 2'b00});
        state_nxt         = (remaining == SizeW'(cur_len)) ? S_IDLE : S_REQUEST;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Slave error aborts the transfer and silences both ports at once.
    if (busy && busError) begin
      state_nxt     = S_IDLE;
      error_nxt     = 1'b1;
      mem_addr_nxt  = '0;
      mem_we_nxt    = 1'b0;
      mem_wdata_nxt = '0;
      bus_start_nxt = 1'b0;
      bus_read_nxt  = 1'b0;
      bus_addr_nxt  = '0;
      bus_len_nxt   = '0;
      wdata_nxt     = '0;
      wvalid_nxt    = 1'b0;
    end

    bus_req_nxt = state_nxt inside {S_REQUEST, S_START, S_READ, S_WRITE, S_WAIT_END};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      phase          <= PH_ADDR;
      cfg_bus_addr   <= '0;
      cfg_mem_addr   <= '0;
      cfg_block      <= '0;
      cfg_burst      <= '0;
      error          <= 1'b0;
      dir_read       <= 1'b0;
      work_bus_addr  <= '0;
      work_mem_addr  <= '0;
      remaining      <= '0;
      cur_len        <= '0;
      beat_cnt       <= '0;
      result         <= '0;
      done           <= 1'b0;
      memAddress     <= '0;
      memWriteEnable <= 1'b0;
      memWriteData   <= '0;
      busRequest     <= 1'b0;
      busStart       <= 1'b0;
      busRead        <= 1'b0;
      busAddress     <= '0;
      busBurstLength <= '0;
      busWriteData   <= '0;
      busWriteValid  <= 1'b0;
    end else begin
      state          <= state_nxt;
      phase          <= phase_nxt;
      cfg_bus_addr   <= cfg_bus_addr_nxt;
      cfg_mem_addr   <= cfg_mem_addr_nxt;
      cfg_block      <= cfg_block_nxt;
      cfg_burst      <= cfg_burst_nxt;
      error          <= error_nxt;
      dir_read       <= dir_read_nxt;
      work_bus_addr  <= work_bus_addr_nxt;
      work_mem_addr  <= work_mem_addr_nxt;
      remaining      <= remaining_nxt;
      cur_len        <= cur_len_nxt;
      beat_cnt       <= beat_cnt_nxt;
      result         <= result_nxt;
      done           <= done_nxt;
      memAddress     <= mem_addr_nxt;
      memWriteEnable <= mem_we_nxt;
      memWriteData   <= mem_wdata_nxt;
      busRequest     <= bus_req_nxt;
      busStart       <= bus_start_nxt;
      busRead        <= bus_read_nxt;
      busAddress     <= bus_addr_nxt;
      busBurstLength <= bus_len_nxt;
      busWriteData   <= wdata_nxt;
      busWriteValid  <= wvalid_nxt;
    end
  end

endmodule

// File: doc/ram_dma_controller.md
Name: ram_dma_controller

Overview:
Custom-instruction-configured DMA engine that moves blocks of 32-bit words between the 512-word local scratchpad and an external burst bus. The CPU programs addresses and sizes and starts transfers through the CI port. The controller then splits each block into bursts, arbitrates for the bus and sequences the scratchpad port. It sits beside the scratchpad CI block and drives that memory's second port.

Parameters:
customId, 8'h00, CI number this block responds to
maxBurst, 256, largest burst length in words supported by the bus (1..256)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  CI start strobe
valueA  input  32  CI operand A: [12:10] register select, [9] write-enable
valueB  input  32  CI operand B: write data
ciN  input  8  CI number
result  output  32  CI read data
done  output  1  CI completion pulse
memAddress  output  9  scratchpad word address
memWriteEnable  output  1  scratchpad write strobe
memWriteData  output  32  scratchpad write data
memReadData  input  32  scratchpad read data, 1-cycle latency after memAddress
busRequest  output  1  bus arbitration request
busGrant  input  1  bus grant
busStart  output  1  1-cycle transaction begin pulse
busRead  output  1  1 = read from bus, 0 = write to bus; valid with busStart
busAddress  output  32  byte start address of burst; valid with busStart
busBurstLength  output  8  burst words minus 1; valid with busStart
busWriteData  output  32  write beat data
busWriteValid  output  1  write beat valid
busWriteReady  input  1  slave accepts write beat
busReadData  input  32  read beat data
busReadValid  input  1  read beat valid
busEnd  input  1  slave signals end of burst
busError  input  1  slave error, abort

Behaviour:
- Reset: all outputs 0; registers 0; state IDLE; error flag 0.
- CI decode: the block is selected when start=1 and ciN==customId. done pulses exactly 1 cycle, the cycle after selection. result is valid only while done=1, else 0.
- Register map (sel=valueA[12:10]; write when valueA[9]=1, otherwise read):
  - 1: busStartAddress[31:0]. Bits [1:0] are forced to 0.
  - 2: memStartAddress[8:0].
  - 3: blockSize[9:0] in words. Writes above 512 saturate to 512.
  - 4: burstSize[7:0]; burst length is burstSize+1, clamped to maxBurst.
  - 5: control/status.
    - Write bit0=1 starts bus→mem. Write bit1=1 starts mem→bus. If both bits are set, bus→mem wins.
    - Read returns {30'b0, error, busy}.
  - Other sel values: writes are ignored, reads return 0.
  - Unread fields read back as 0.
- While busy:
  - Writes to sel 1-4 are ignored.
  - Start commands are ignored.
  - done is still returned.
- Start with blockSize=0: no bus activity; busy stays 0; error is cleared.
- Every accepted start clears error.
- State machine:
  - IDLE → REQUEST on accepted start. Load working bus address, local address and remaining count; busy=1.
  - REQUEST: busRequest=1 until busGrant=1 → START.
  - START: 1-cycle busStart with busRead, busAddress and busBurstLength = min(burst, remaining)-1. Next state is READ or WRITE.
  - READ: each busReadValid cycle writes busReadData to memAddress (memWriteEnable=1) and increments the local address. Beats beyond the burst length are ignored.
  - WRITE: prefetch the scratchpad word, hold it in busWriteData with busWriteValid=1 until busWriteReady=1, then advance. At most 1 bubble per beat is allowed. After the last beat, go to WAIT_END.
  - WAIT_END / end of READ: on busEnd, busRequest drops for 1 cycle and the controller goes to NEXT.
  - NEXT: remaining -= burst and busAddress += 4*burst. If remaining=0 → IDLE with busy=0, else → REQUEST.
- busReadValid and busEnd in the same cycle: the beat is written first, then the burst ends.
- Local address wraps 511→0.
- Bus address wraps modulo 2^32.
- busError in any non-IDLE state: abort immediately.
  - All bus outputs and memWriteEnable go to 0.
  - error=1, busy=0, state → IDLE.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. Registers clear.

Test Plan:
- Config readback: write sel1=0x1000_0003, sel2=0x1F0, sel3=600, sel4=3. Reads return 0x1000_0000, 0x1F0, 512, 3; each done is 1 cycle wide.
- Bus→mem: bus=0x2000, mem=510, size=6, burst=3. Required: two bursts (addr 0x2000 len 3, addr 0x2010 len 1). Scratchpad writes go to 510, 511, 0, 1, 2, 3 with data in order. Status reads busy=1 during the transfer, then 0.
- Mem→bus with busWriteReady low for 3 cycles on beat 2. Required: busWriteData is held stable while stalled. Beats match scratchpad contents, with no loss or duplication.
- Start while busy plus a write to sel1 during the transfer. Required: the transfer is unaffected and sel1 still reads the original value.
- busError mid-burst on the 2nd read beat. Required: next cycle busRequest=0, memWriteEnable=0 and status=0b10. A new start clears error.
- blockSize=0 start: no busRequest ever asserted, status=0. Then assert reset during an active burst: all outputs 0 on the next cycle.
